// File: rtl/task_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : task_arb_pkg
// Brief    : Shared types and the round-robin pick function for task_arb_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package task_arb_pkg;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Search starts one past the previous winner and wraps modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                         input logic [MAX_ID_W-1:0] last,
                                         input int                  n);
        rr_pick_t r;
        int       idx;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (!r.valid && req[idx[MAX_ID_W-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = idx[MAX_ID_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/task_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : task_arb_rr_pick
// Brief    : Combinational round-robin priority picker over N_REQ requests.
// Revision : 1.0 - initial release
// ============================================================================
module task_arb_rr_pick
    import task_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [id_width(N_REQ)-1:0] last,
    output logic                       valid,
    output logic [id_width(N_REQ)-1:0] idx
);

    localparam int c_ID_W = id_width(N_REQ);

    rr_pick_t w_pick;

    always_comb begin
        w_pick = rr_pick(MAX_REQ'(req), MAX_ID_W'(last), N_REQ);
        valid  = w_pick.valid;
        idx    = c_ID_W'(w_pick.idx);
    end

endmodule
`default_nettype wire

// File: rtl/task_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : task_arb_ctrl
// Brief    : Round-robin arbiter serialising calls into one shared task engine.
// Revision : 1.0 - initial release
// ============================================================================
module task_arb_ctrl
    import task_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           Req,
    output logic [N_REQ-1:0]           Ack,
    output logic                       AckErr,
    output logic                       Start,
    output logic [id_width(N_REQ)-1:0] ReqId,
    input  logic                       EngDone,
    output logic                       Busy
);

    localparam int c_ID_W = id_width(N_REQ);
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    state_t              state_q,    state_d;
    logic [c_ID_W-1:0]   last_q,     last_d;
    logic [c_ID_W-1:0]   req_id_q,   req_id_d;
    logic [c_WD_W-1:0]   wd_q,       wd_d;
    logic [N_REQ-1:0]    ack_q,      ack_d;
    logic                ack_err_q,  ack_err_d;
    logic                start_q,    start_d;
    logic                busy_q,     busy_d;
    logic                spurious_q, spurious_d;

    logic                w_pick_valid;
    logic [c_ID_W-1:0]   w_pick_idx;

    task_arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (Req),
        .last  (last_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        req_id_d   = req_id_q;
        wd_d       = wd_q;
        ack_d      = '0;
        ack_err_d  = 1'b0;
        start_d    = 1'b0;
        spurious_d = spurious_q;

        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    req_id_d = w_pick_idx;
                    start_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = c_WD_W'(TIMEOUT);
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (EngDone || (wd_q == c_WD_W'(1))) begin
                    ack_d     = N_REQ'(1) << req_id_q;
                    ack_err_d = ~EngDone;
                    state_d   = ACK;
                end else begin
                    wd_d = wd_q - c_WD_W'(1);
                end
            end
            ACK: begin
                last_d  = req_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (EngDone && ((state_q == IDLE) || (state_q == ISSUE))) begin
            spurious_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_q     <= c_ID_W'(N_REQ - 1);
            req_id_q   <= '0;
            wd_q       <= '0;
            ack_q      <= '0;
            ack_err_q  <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            req_id_q   <= req_id_d;
            wd_q       <= wd_d;
            ack_q      <= ack_d;
            ack_err_q  <= ack_err_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
        end
    end

    assign Ack    = ack_q;
    assign AckErr = ack_err_q;
    assign Start  = start_q;
    assign ReqId  = req_id_q;
    assign Busy   = busy_q;

    spurious_engdone_cov: cover property (@(posedge Clk) disable iff (Reset)
        !spurious_q && spurious_d);

endmodule
`default_nettype wire

// File: tb/tb_task_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_arb_ctrl
// Brief    : Directed self-checking bench for task_arb_ctrl (N_REQ=4, TIMEOUT=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_task_arb_ctrl;

    localparam int c_N_REQ   = 4;
    localparam int c_TIMEOUT = 5;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [c_N_REQ-1:0]   Req;
    logic [c_N_REQ-1:0]   Ack;
    logic                 AckErr;
    logic                 Start;
    logic [1:0]           ReqId;
    logic                 EngDone;
    logic                 Busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task_arb_ctrl #(
        .N_REQ   (c_N_REQ),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .Ack     (Ack),
        .AckErr  (AckErr),
        .Start   (Start),
        .ReqId   (ReqId),
        .EngDone (EngDone),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_start(output int at);
        int n = 0;
        while (Start !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("start_seen", {31'd0, Start}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_ack(output int at);
        int n = 0;
        while (Ack === '0 && n < 30) begin
            tick();
            n++;
        end
        check("ack_seen", {31'd0, (Ack !== '0)}, 32'd1);
        at = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int t, s, s2, a, prev;
        Reset   = 1'b1;
        Req     = '0;
        EngDone = 1'b0;

        // Reset state
        apply_reset();
        check("rst_ack",    Ack,    0);
        check("rst_ackerr", AckErr, 0);
        check("rst_start",  Start,  0);
        check("rst_reqid",  ReqId,  0);
        check("rst_busy",   Busy,   0);

        // Single requester, engine done 3 cycles after Start
        Req = 4'b0100;
        t = cyc;
        tick();
        check("single_start",     Start,   1);
        check("single_start_lat", cyc - t, 1);
        check("single_reqid",     ReqId,   2);
        check("single_busy",      Busy,    1);
        s = cyc;
        tick();
        check("single_start_pulse", Start, 0);
        tick();
        tick();
        check("single_no_early_ack", Ack, 0);
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0;
        check("single_ack",     Ack,     4'b0100);
        check("single_ackerr",  AckErr,  0);
        check("single_latency", cyc - s, 4);
        check("single_busy_ack", Busy,   1);
        Req = '0;
        tick();
        check("single_ack_pulse", Ack,  0);
        check("single_idle_busy", Busy, 0);

        // Fairness with all requests held, engine finishing in one cycle
        apply_reset();
        Req  = 4'b1111;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            wait_start(s);
            check("rr_reqid", ReqId, k % 4);
            tick();
            EngDone = 1'b1;
            tick();
            EngDone = 1'b0;
            check("rr_ack",    Ack,    32'd1 << (k % 4));
            check("rr_ackerr", AckErr, 0);
            if (k > 0) check("rr_spacing", cyc - prev, 4);
            prev = cyc;
            if (k == 7) Req = '0;
        end

        // Timeout, then next requester served
        Req = 4'b0011;
        wait_start(s);
        check("to_reqid", ReqId, 0);
        wait_ack(a);
        check("to_latency", a - s,  c_TIMEOUT + 1);
        check("to_ack",     Ack,    4'b0001);
        check("to_ackerr",  AckErr, 1);
        Req = 4'b0010;
        wait_start(s2);
        check("to_next_reqid", ReqId,  1);
        check("to_next_gap",   s2 - a, 2);

        // Done on the last watchdog cycle; request dropped mid-call
        tick();
        Req = '0;
        tick();
        tick();
        tick();
        tick();
        check("tie_no_early_ack", Ack, 0);
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0;
        check("tie_latency", cyc - s2, c_TIMEOUT + 1);
        check("tie_ack",     Ack,      4'b0010);
        check("tie_ackerr",  AckErr,   0);

        // Reset during WAIT while serving requester 3
        Req = 4'b1000;
        wait_start(s);
        check("mid_reqid", ReqId, 3);
        tick();
        tick();
        Reset = 1'b1;
        Req   = '0;
        tick();
        check("mid_ack",    Ack,    0);
        check("mid_ackerr", AckErr, 0);
        check("mid_start",  Start,  0);
        check("mid_reqid0", ReqId,  0);
        check("mid_busy",   Busy,   0);
        Reset = 1'b0;
        Req   = 4'b1001;
        wait_start(s);
        check("mid_next_reqid", ReqId, 0);
        tick();
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0;
        check("mid_next_ack", Ack, 4'b0001);
        Req = '0;
        tick();
        tick();

        // Spurious EngDone while idle
        check("spur_flag_clear", {31'd0, dut.spurious_q}, 0);
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0;
        check("spur_ack",   Ack,   0);
        check("spur_start", Start, 0);
        check("spur_busy",  Busy,  0);
        tick();
        check("spur_start2", Start, 0);
        check("spur_busy2",  Busy,  0);
        check("spur_flag",   {31'd0, dut.spurious_q}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
